// File: rtl/if_stage_if.sv
// -----------------------------------------------------------------------------
// if_stage_if
//   Request/acknowledge instruction-memory port used by the fetch stage.
//   The fetch side (master) raises imem_req with a word address and keeps the
//   address stable until the memory (slave) answers with imem_ack and the
//   instruction word on imem_rdata. Memory latency is arbitrary.
//
//   Signals:
//     imem_req    master -> slave  fetch request
//     imem_addr   master -> slave  fetch address (held while req && !ack)
//     imem_ack    slave  -> master data returned this cycle
//     imem_rdata  slave  -> master instruction word, valid with imem_ack
// -----------------------------------------------------------------------------
interface if_stage_if #(
   parameter int WORD_WIDTH = 32
);
   logic                  imem_req;
   logic [WORD_WIDTH-1:0] imem_addr;
   logic                  imem_ack;
   logic [WORD_WIDTH-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage feeding decode. Owns the fetch PC, drives a
//   variable-latency request/acknowledge memory port and presents
//   {fetched address + 4, instruction, valid} through an output register.
//
//   A decode freeze holds the output register; an instruction that arrives
//   while frozen is parked in a one-entry hold buffer and requests stop until
//   decode accepts it. A branch redirect from EX flushes the output register
//   and the hold buffer; if a memory request is still outstanding at that
//   point the stage keeps that request alive (same address) until it is
//   acknowledged and throws the returned word away before fetching the target.
//
//   Ports:
//     clk             clock, all state changes on the rising edge
//     rst             asynchronous reset, active low
//     freeze          decode stall, output register holds
//     branch_taken    one-cycle redirect pulse
//     branch_address  redirect target (low two bits ignored)
//     imem            instruction-memory port (master side)
//     pc              fetched address + 4
//     instruction     fetched instruction
//     valid           pc/instruction carry a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module if_stage #(
   parameter int                    WORD_WIDTH = 32,
   parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  branch_taken,
   input  logic [WORD_WIDTH-1:0] branch_address,
   if_stage_if.master            imem,
   output logic [WORD_WIDTH-1:0] pc,
   output logic [WORD_WIDTH-1:0] instruction,
   output logic                  valid
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

   state_t                state_q,      state_d;
   logic [WORD_WIDTH-1:0] fetch_pc_q,   fetch_pc_d;
   logic [WORD_WIDTH-1:0] drain_addr_q, drain_addr_d;
   logic [WORD_WIDTH-1:0] out_pc_q,     out_pc_d;
   logic [WORD_WIDTH-1:0] out_instr_q,  out_instr_d;
   logic                  out_valid_q,  out_valid_d;
   logic [WORD_WIDTH-1:0] hold_pc_q,    hold_pc_d;
   logic [WORD_WIDTH-1:0] hold_instr_q, hold_instr_d;
   logic                  hold_full_q,  hold_full_d;

   logic [WORD_WIDTH-1:0] fetch_pc_inc;
   logic [WORD_WIDTH-1:0] branch_target;
   logic                  fetch_done;
   logic                  req_in_flight;
   logic                  unused_branch_lsbs;

   // Wraps modulo 2^WORD_WIDTH, so the word at the top of memory is followed
   // by address zero.
   assign fetch_pc_inc  = fetch_pc_q + PC_STEP;
   assign branch_target = {branch_address[WORD_WIDTH-1:2], 2'b00};

   // An acknowledge only counts as a fetched instruction in REQ; in DRAIN it
   // closes a stale request and in IDLE/HOLD no request is outstanding.
   assign fetch_done    = (state_q == ST_REQ) && imem.imem_ack;
   assign req_in_flight = (state_q == ST_REQ) && !imem.imem_ack;

   assign unused_branch_lsbs = ^branch_address[1:0];

   // ---------------------------------------------------------------------------
   // State and control registers (asynchronous reset)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC;
         out_pc_q    <= '0;
         out_instr_q <= '0;
         out_valid_q <= 1'b0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_valid_q <= out_valid_d;
         hold_full_q <= hold_full_d;
      end
   end

   // Pure data storage: only ever read when the matching state/flag says the
   // contents are meaningful, so no reset is needed.
   always_ff @(posedge clk) begin
      drain_addr_q <= drain_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end
         ST_REQ: begin
            if (branch_taken) begin
               // An outstanding request cannot be withdrawn; wait for its ack.
               state_d = imem.imem_ack ? ST_REQ : ST_DRAIN;
            end else if (imem.imem_ack && freeze) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (branch_taken || !freeze) begin
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem.imem_ack) begin
               state_d = ST_REQ;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Fetch PC, hold buffer and output register update
   // ---------------------------------------------------------------------------
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      hold_full_d  = hold_full_q;
      out_pc_d     = out_pc_q;
      out_instr_d  = out_instr_q;
      out_valid_d  = out_valid_q;

      if (branch_taken) begin
         // Redirect wins over freeze and over any returning data.
         fetch_pc_d  = branch_target;
         hold_full_d = 1'b0;
         out_valid_d = 1'b0;
         out_instr_d = '0;
         // Remember the address of the request being drained so the bus
         // stays stable. A second redirect while draining keeps the original.
         if (req_in_flight) begin
            drain_addr_d = fetch_pc_q;
         end
      end else begin
         if (fetch_done) begin
            fetch_pc_d = fetch_pc_inc;
         end

         if (freeze) begin
            // Output register is untouchable while frozen, even if it holds a
            // bubble; fresh data goes to the hold buffer instead.
            if (fetch_done) begin
               hold_pc_d    = fetch_pc_inc;
               hold_instr_d = imem.imem_rdata;
               hold_full_d  = 1'b1;
            end
         end else begin
            out_valid_d = 1'b0;
            if (fetch_done) begin
               out_pc_d    = fetch_pc_inc;
               out_instr_d = imem.imem_rdata;
               out_valid_d = 1'b1;
            end else if ((state_q == ST_HOLD) && hold_full_q) begin
               out_pc_d    = hold_pc_q;
               out_instr_d = hold_instr_q;
               out_valid_d = 1'b1;
               hold_full_d = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      imem.imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
      imem.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
      pc             = out_pc_q;
      instruction    = out_instr_q;
      valid          = out_valid_q;
   end

`ifndef SYNTHESIS
   // Memory port contract: an unanswered request stays up with a fixed address.
   a_addr_stable : assert property (
      @(posedge clk) disable iff (!rst)
      (imem.imem_req && !imem.imem_ack) |=> (imem.imem_req && $stable(imem.imem_addr))
   );

   // HOLD is only ever entered with a parked instruction.
   a_hold_full : assert property (
      @(posedge clk) disable iff (!rst)
      (state_q == ST_HOLD) |-> hold_full_q
   );
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam int WW = 32;

   typedef struct packed {
      logic [WW-1:0] pc;
      logic [WW-1:0] ins;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          freeze = 1'b0;
   logic          branch_taken = 1'b0;
   logic [WW-1:0] branch_address = '0;
   logic [WW-1:0] pc;
   logic [WW-1:0] instruction;
   logic          valid;

   if_stage_if #(.WORD_WIDTH(WW)) mif ();

   if_stage #(
      .WORD_WIDTH (WW),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_address (branch_address),
      .imem           (mif),
      .pc             (pc),
      .instruction    (instruction),
      .valid          (valid)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   logic drain_pending = 1'b0;
   int   lat = 0;
   int   cnt = 0;

   logic          e_req, e_ack, e_frz, e_br;
   logic [WW-1:0] e_addr, e_rdata;

   task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WW-1:0] mem_word(input logic [WW-1:0] a);
      if (a == 32'h0000_0020) return 32'hE3A0_1005;
      return a ^ 32'hC0DE_0000;
   endfunction

   // Scoreboard: every instruction the memory hands over while a live fetch
   // is outstanding is expected at decode, in order, unless a redirect
   // kills it first.
   task automatic sb_update();
      exp_t e;
      if (!rst) begin
         sb_q.delete();
         drain_pending = 1'b0;
         return;
      end
      if (e_br) begin
         sb_q.delete();
         drain_pending = e_req && !e_ack;
         check_val("br_valid", {31'b0, valid}, 32'd0);
         check_val("br_instr", instruction, 32'd0);
         return;
      end
      if (e_req && e_ack) begin
         if (drain_pending) drain_pending = 1'b0;
         else sb_q.push_back('{pc: e_addr + 32'd4, ins: e_rdata});
      end
      if (!e_frz) begin
         if (valid) begin
            if (sb_q.size() == 0) begin
               check_val("sb_spurious", {31'b0, valid}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_val("sb_pc", pc, e.pc);
               check_val("sb_instr", instruction, e.ins);
            end
         end
         check_val("sb_pending", sb_q.size(), 32'd0);
      end
   endtask

   // One clock: memory model answers on the falling edge, DUT outputs are
   // inspected 1ns after the rising edge.
   task automatic cycle();
      @(negedge clk);
      if (!rst || !mif.imem_req) begin
         cnt = 0;
         mif.imem_ack = 1'b0;
      end else begin
         mif.imem_ack = (cnt >= lat);
         cnt = mif.imem_ack ? 0 : cnt + 1;
      end
      mif.imem_rdata = mif.imem_ack ? mem_word(mif.imem_addr) : 32'hDEAD_BEEF;
      e_req   = mif.imem_req;
      e_ack   = mif.imem_ack;
      e_addr  = mif.imem_addr;
      e_rdata = mif.imem_rdata;
      e_frz   = freeze;
      e_br    = branch_taken;
      @(posedge clk);
      #1;
      branch_taken = 1'b0;
      sb_update();
   endtask

   task automatic run_until_addr(input logic [WW-1:0] target, input int bound);
      for (int i = 0; i < bound && mif.imem_addr != target; i++) cycle();
      check_val("reach_addr", mif.imem_addr, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      mif.imem_ack   = 1'b0;
      mif.imem_rdata = '0;

      // Reset state
      cycle();
      cycle();
      check_val("rst_req", {31'b0, mif.imem_req}, 32'd0);
      check_val("rst_pc", pc, 32'd0);
      check_val("rst_instr", instruction, 32'd0);
      check_val("rst_valid", {31'b0, valid}, 32'd0);
      rst = 1'b1;

      // 1: back-to-back fetch with ack tied high
      lat = 0;
      cycle();
      check_val("t1_req", {31'b0, mif.imem_req}, 32'd1);
      check_val("t1_addr0", mif.imem_addr, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         check_val("t1_addr", mif.imem_addr, 32'(4 * i));
         check_val("t1_valid", {31'b0, valid}, 32'd1);
         check_val("t1_pc", pc, 32'(4 * i));
      end

      // 2: two-cycle memory latency at 0x10
      lat = 2;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check_val("t2_addr_hold", mif.imem_addr, 32'h10);
         check_val("t2_bubble", {31'b0, valid}, 32'd0);
      end
      cycle();
      check_val("t2_valid", {31'b0, valid}, 32'd1);
      check_val("t2_pc", pc, 32'h14);
      check_val("t2_next_addr", mif.imem_addr, 32'h14);
      lat = 0;

      // 3: freeze while 0x20 returns
      run_until_addr(32'h20, 10);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_val("t3_req_low", {31'b0, mif.imem_req}, 32'd0);
         check_val("t3_pc_hold", pc, 32'h20);
         check_val("t3_instr_hold", instruction, 32'hC0DE_001C);
         check_val("t3_valid_hold", {31'b0, valid}, 32'd1);
      end
      freeze = 1'b0;
      cycle();
      check_val("t3_instr", instruction, 32'hE3A0_1005);
      check_val("t3_pc", pc, 32'h24);
      check_val("t3_valid", {31'b0, valid}, 32'd1);
      check_val("t3_resume", mif.imem_addr, 32'h24);

      // 4: redirect with a request to 0x40 outstanding
      run_until_addr(32'h40, 16);
      lat = 3;
      cycle();
      branch_taken   = 1'b1;
      branch_address = 32'h0000_0103;
      cycle();
      check_val("t4_drain_req", {31'b0, mif.imem_req}, 32'd1);
      check_val("t4_drain_addr", mif.imem_addr, 32'h40);
      for (int k = 0; k < 6; k++) begin
         cycle();
         if (mif.imem_addr != 32'h40) break;
         check_val("t4_drain_bubble", {31'b0, valid}, 32'd0);
      end
      check_val("t4_target", mif.imem_addr, 32'h100);
      check_val("t4_discard", {31'b0, valid}, 32'd0);
      lat = 0;
      cycle();
      check_val("t4_pc", pc, 32'h104);
      check_val("t4_valid", {31'b0, valid}, 32'd1);

      // 5: redirect while frozen with the hold buffer full
      freeze = 1'b1;
      cycle();
      check_val("t5_req_low", {31'b0, mif.imem_req}, 32'd0);
      cycle();
      branch_taken   = 1'b1;
      branch_address = 32'h0000_0200;
      cycle();
      check_val("t5_valid", {31'b0, valid}, 32'd0);
      check_val("t5_addr", mif.imem_addr, 32'h200);
      freeze = 1'b0;
      cycle();
      check_val("t5_pc", pc, 32'h204);
      check_val("t5_instr", instruction, 32'h200 ^ 32'hC0DE_0000);

      // 6a: PC wrap at the top of the address space
      branch_taken   = 1'b1;
      branch_address = 32'hFFFF_FFFF;
      cycle();
      check_val("t6_addr_top", mif.imem_addr, 32'hFFFF_FFFC);
      cycle();
      check_val("t6_pc_wrap", pc, 32'h0);
      check_val("t6_valid", {31'b0, valid}, 32'd1);
      check_val("t6_addr_wrap", mif.imem_addr, 32'h0);
      cycle();
      check_val("t6_pc_after", pc, 32'h4);

      // 6b: asynchronous reset in the middle of a drain
      lat = 3;
      cycle();
      branch_taken   = 1'b1;
      branch_address = 32'h0000_0300;
      cycle();
      check_val("t6_drain_addr", mif.imem_addr, 32'h4);
      #2 rst = 1'b0;
      #1;
      check_val("t6_arst_pc", pc, 32'h0);
      check_val("t6_arst_instr", instruction, 32'h0);
      check_val("t6_arst_valid", {31'b0, valid}, 32'd0);
      check_val("t6_arst_req", {31'b0, mif.imem_req}, 32'd0);
      lat = 0;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      check_val("t6_first_req", {31'b0, mif.imem_req}, 32'd1);
      check_val("t6_first_addr", mif.imem_addr, 32'h0);
      cycle();
      check_val("t6_first_pc", pc, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
